// File: rtl/svpwm_modulator_if.sv
// Alpha/beta sample handshake between the Clarke stage (master) and the
// space-vector modulator (slave). A transfer happens when in_valid & in_ready.
interface svpwm_modulator_if;
    logic signed [15:0] alpha;
    logic signed [15:0] beta;
    logic               in_valid;
    logic               in_ready;

    modport master (output alpha, output beta, output in_valid, input in_ready);
    modport slave  (input alpha, input beta, input in_valid, output in_ready);
endinterface

// File: rtl/svpwm_modulator.sv
// Space-vector PWM modulator. One alpha/beta sample per handshake goes through
// a 4-stage pipeline (inverse Clarke, max/min + sector, zero-sequence injection
// with clamping, scaling to carrier counts) into a pending register. The pending
// set becomes active only at the carrier valley, and the three phase outputs are
// compared against a symmetric up/down carrier.
module svpwm_modulator #(
    parameter int unsigned PERIOD = 1000,
    parameter int unsigned CW     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    svpwm_modulator_if.slave in_if,
    output logic             pwm_a,
    output logic             pwm_b,
    output logic             pwm_c,
    output logic [2:0]       sector,
    output logic             period_start
);
    localparam logic [CW-1:0]        PER   = CW'(PERIOD);
    localparam logic [CW-1:0]        ZERO  = CW'(0);
    localparam logic [CW-1:0]        ONE   = CW'(1);
    localparam logic signed [33:0]   K_Q15 = 34'sd28378;
    localparam logic signed [19:0]   HALF  = 20'sd16384;
    localparam logic signed [19:0]   FULL  = 20'sd32768;

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    // Duty in Q15 limited to [0, 1.0]; values outside mean over-modulation.
    function automatic logic [15:0] clamp_duty(input logic signed [19:0] d);
        logic [15:0] r;
        if (d < 20'sd0) begin
            r = 16'd0;
        end else if (d > FULL) begin
            r = 16'd32768;
        end else begin
            r = d[15:0];
        end
        return r;
    endfunction

    // Duty (Q15) to carrier counts, rounded half up.
    function automatic logic [CW-1:0] scale_cmp(input logic [15:0] d);
        logic [47:0] p;
        p = 48'(d) * 48'(PERIOD) + 48'd16384;
        return CW'(p >> 15);
    endfunction

    // Carrier and handshake state
    dir_e              dir_q, dir_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valley_s, accept_s;
    logic              busy_q, pend_v_q;

    // Pipeline state
    logic              s1_v_q, s2_v_q, s3_v_q;
    logic signed [17:0] alpha_s, half_neg_s, kb_s, va_d, vb_d, vc_d;
    logic signed [33:0] kb_prod_s;
    logic signed [17:0] va_q, vb_q, vc_q;
    logic signed [17:0] va2_q, vb2_q, vc2_q, vmax_q, vmin_q, vmax_d, vmin_d;
    logic [1:0]        imax_s, imin_s;
    logic [2:0]        sec_d, sec2_q, sec3_q;
    logic signed [18:0] sum_s, off_s;
    logic [15:0]       da_d, db_d, dc_d, da_q, db_q, dc_q;
    logic [CW-1:0]     cmp_a_d, cmp_b_d, cmp_c_d;
    logic [CW-1:0]     pend_a_q, pend_b_q, pend_c_q, act_a_q, act_b_q, act_c_q;
    logic [2:0]        pend_sec_q, act_sec_q;

    assign valley_s       = (cnt_q == ZERO);
    assign in_if.in_ready = ~busy_q & ~pend_v_q;
    assign accept_s       = in_if.in_valid & in_if.in_ready;

    // S1: inverse Clarke into three phase references (18-bit, floor shifts)
    always_comb begin
        alpha_s    = 18'(in_if.alpha);
        half_neg_s = (-alpha_s) >>> 1;
        kb_prod_s  = K_Q15 * 34'(in_if.beta);
        kb_s       = 18'(kb_prod_s >>> 15);
        va_d       = alpha_s;
        vb_d       = half_neg_s + kb_s;
        vc_d       = half_neg_s - kb_s;
    end

    // S2: max/min with fixed tie preference, and sector from the (max,min) pair
    always_comb begin
        if ((vc_q > va_q) && (vc_q > vb_q)) begin
            vmax_d = vc_q; imax_s = 2'd2;
        end else if (vb_q > va_q) begin
            vmax_d = vb_q; imax_s = 2'd1;
        end else begin
            vmax_d = va_q; imax_s = 2'd0;
        end
        if ((va_q < vb_q) && (va_q < vc_q)) begin
            vmin_d = va_q; imin_s = 2'd0;
        end else if (vb_q < vc_q) begin
            vmin_d = vb_q; imin_s = 2'd1;
        end else begin
            vmin_d = vc_q; imin_s = 2'd2;
        end
        case ({imax_s, imin_s})
            4'b00_10: sec_d = 3'd1;
            4'b01_10: sec_d = 3'd2;
            4'b01_00: sec_d = 3'd3;
            4'b10_00: sec_d = 3'd4;
            4'b10_01: sec_d = 3'd5;
            4'b00_01: sec_d = 3'd6;
            default:  sec_d = 3'd1;
        endcase
    end

    // S3: min-max zero-sequence offset, re-centre at 0.5 and clamp each duty
    always_comb begin
        sum_s = 19'(vmax_q) + 19'(vmin_q);
        off_s = -(sum_s >>> 1);
        da_d  = clamp_duty(20'(va2_q) + 20'(off_s) + HALF);
        db_d  = clamp_duty(20'(vb2_q) + 20'(off_s) + HALF);
        dc_d  = clamp_duty(20'(vc2_q) + 20'(off_s) + HALF);
    end

    // S4: duties to compare counts
    always_comb begin
        cmp_a_d = scale_cmp(da_q);
        cmp_b_d = scale_cmp(db_q);
        cmp_c_d = scale_cmp(dc_q);
    end

    // Pipeline registers S1..S3 with their valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0; s2_v_q <= 1'b0; s3_v_q <= 1'b0;
            va_q   <= 18'sd0; vb_q  <= 18'sd0; vc_q  <= 18'sd0;
            va2_q  <= 18'sd0; vb2_q <= 18'sd0; vc2_q <= 18'sd0;
            vmax_q <= 18'sd0; vmin_q <= 18'sd0;
            sec2_q <= 3'd1;   sec3_q <= 3'd1;
            da_q   <= 16'd0;  db_q  <= 16'd0;  dc_q  <= 16'd0;
        end else begin
            s1_v_q <= accept_s;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            if (accept_s) begin
                va_q <= va_d; vb_q <= vb_d; vc_q <= vc_d;
            end
            if (s1_v_q) begin
                va2_q <= va_q; vb2_q <= vb_q; vc2_q <= vc_q;
                vmax_q <= vmax_d; vmin_q <= vmin_d; sec2_q <= sec_d;
            end
            if (s2_v_q) begin
                da_q <= da_d; db_q <= db_d; dc_q <= dc_d; sec3_q <= sec2_q;
            end
        end
    end

    // Busy/pending/active bookkeeping; a result landing on the valley waits a period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            pend_v_q <= 1'b0;
            pend_a_q <= ZERO; pend_b_q <= ZERO; pend_c_q <= ZERO; pend_sec_q <= 3'd1;
            act_a_q  <= ZERO; act_b_q  <= ZERO; act_c_q  <= ZERO; act_sec_q  <= 3'd1;
        end else begin
            if (accept_s) begin
                busy_q <= 1'b1;
            end else if (s3_v_q) begin
                busy_q <= 1'b0;
            end
            if (s3_v_q) begin
                pend_v_q   <= 1'b1;
                pend_a_q   <= cmp_a_d;
                pend_b_q   <= cmp_b_d;
                pend_c_q   <= cmp_c_d;
                pend_sec_q <= sec3_q;
            end else if (valley_s) begin
                pend_v_q <= 1'b0;
            end
            if (valley_s && pend_v_q) begin
                act_a_q   <= pend_a_q;
                act_b_q   <= pend_b_q;
                act_c_q   <= pend_c_q;
                act_sec_q <= pend_sec_q;
            end
        end
    end

    // Carrier direction FSM and counter next state (0..PERIOD..1, repeat)
    always_comb begin
        dir_d = dir_q;
        cnt_d = cnt_q;
        case (dir_q)
            DIR_UP: begin
                if (cnt_q >= PER) begin
                    dir_d = DIR_DOWN;
                    cnt_d = cnt_q - ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DIR_DOWN: begin
                if (cnt_q == ZERO) begin
                    dir_d = DIR_UP;
                    cnt_d = cnt_q + ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                dir_d = DIR_UP;
                cnt_d = ZERO;
            end
        endcase
    end

    // Carrier state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= DIR_UP;
            cnt_q <= ZERO;
        end else begin
            dir_q <= dir_d;
            cnt_q <= cnt_d;
        end
    end

    // Registered gate commands, sector and valley pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            pwm_c        <= 1'b0;
            sector       <= 3'd1;
            period_start <= 1'b0;
        end else begin
            pwm_a        <= (act_a_q >= PER) | (cnt_q < act_a_q);
            pwm_b        <= (act_b_q >= PER) | (cnt_q < act_b_q);
            pwm_c        <= (act_c_q >= PER) | (cnt_q < act_c_q);
            sector       <= act_sec_q;
            period_start <= valley_s;
        end
    end
endmodule

// File: tb/tb_svpwm_modulator.sv
// Directed bench for svpwm_modulator with PERIOD=1000: reset, fixed vectors,
// clamping, valley-synchronous update/handshake, mid-run reset, angle sweep.
module tb_svpwm_modulator;
    localparam int PERIOD = 1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       pwm_a, pwm_b, pwm_c, period_start;
    logic [2:0] sector;
    int         total = 0;
    int         bad   = 0;

    int sw_al  [12] = '{15826, 11585, 4240, -4240, -11585, -15826,
                        -15826, -11585, -4240, 4240, 11585, 15826};
    int sw_be  [12] = '{4240, 11585, 15826, 15826, 11585, 4240,
                        -4240, -11585, -15826, -15826, -11585, -4240};
    int sw_sec [12] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};

    svpwm_modulator_if u_if ();

    svpwm_modulator #(.PERIOD(PERIOD), .CW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_if        (u_if.slave),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .pwm_c        (pwm_c),
        .sector       (sector),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input int a, input int b);
        int n;
        n = 0;
        while (u_if.in_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, int'(n < 5000), 1);
        u_if.alpha    = 16'(a);
        u_if.beta     = 16'(b);
        u_if.in_valid = 1'b1;
        tick();
        u_if.in_valid = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (period_start !== 1'b1 && n < 2100);
        check({tag, "_valley"}, period_start, 1);
    endtask

    // Observes one full period after a valley pulse and checks high counts,
    // the low window of phase a, the sector and the valley pulse spacing.
    task automatic expect_period(input string tag, input int ea, input int eb, input int ec,
                                 input int efl, input int ell, input int esec);
        int ha, hb, hc, fl, ll;
        logic ps_mid;
        ha = 0; hb = 0; hc = 0; fl = -1; ll = -1; ps_mid = 1'b1;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            tick();
            ha += int'(pwm_a);
            hb += int'(pwm_b);
            hc += int'(pwm_c);
            if (pwm_a !== 1'b1) begin
                if (fl < 0) fl = k;
                ll = k;
            end
            if (k == PERIOD) ps_mid = period_start;
        end
        check({tag, "_high_a"}, ha, ea);
        check({tag, "_high_b"}, hb, eb);
        check({tag, "_high_c"}, hc, ec);
        check({tag, "_lowstart_a"}, fl, efl);
        check({tag, "_lowend_a"}, ll, ell);
        check({tag, "_sector"}, sector, esec);
        check({tag, "_ps_peak"}, ps_mid, 0);
        check({tag, "_ps_next"}, period_start, 1);
    endtask

    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) q--;
        return q;
    endfunction

    // Reference: compare value for one phase of an alpha/beta sample.
    function automatic int ref_cmp(input int a, input int b, input int ph);
        int v[3];
        int mx, mn, off, d;
        v[0] = a;
        v[1] = fdiv(-a, 2) + fdiv(28378 * b, 32768);
        v[2] = fdiv(-a, 2) - fdiv(28378 * b, 32768);
        mx = v[0]; mn = v[0];
        for (int i = 1; i < 3; i++) begin
            if (v[i] > mx) mx = v[i];
            if (v[i] < mn) mn = v[i];
        end
        off = -fdiv(mx + mn, 2);
        d = v[ph] + off + 16384;
        if (d < 0) d = 0;
        if (d > 32768) d = 32768;
        return fdiv(d * PERIOD + 16384, 32768);
    endfunction

    initial begin
        int early, changed, n;
        u_if.alpha = 16'sd0; u_if.beta = 16'sd0; u_if.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        tick(); tick(); tick();
        // Reset state
        check("rst_pwm_a", pwm_a, 0);
        check("rst_pwm_b", pwm_b, 0);
        check("rst_pwm_c", pwm_c, 0);
        check("rst_sector", sector, 1);
        check("rst_ps", period_start, 0);
        check("rst_ready", u_if.in_ready, 1);
        rst_n = 1'b1;

        // Zero reference: 50% on every phase, centred on the valley
        send("t2", 0, 0);
        wait_ps("t2");
        expect_period("t2", 999, 999, 999, 500, 1500, 1);

        // Pure alpha and pure beta at half amplitude
        send("t3a", 16384, 0);
        wait_ps("t3a");
        expect_period("t3a", 1749, 249, 249, 875, 1125, 1);
        send("t3b", 0, 16384);
        wait_ps("t3b");
        expect_period("t3b", 999, 1865, 133, 500, 1500, 2);

        // Over-modulation: a clamps high, b/c clamp low
        send("t4", 32767, 0);
        wait_ps("t4");
        expect_period("t4", 2000, 0, 0, -1, -1, 1);

        // Sample accepted mid-period, second sample held on the bus
        for (int i = 0; i < 500; i++) tick();
        send("t5s1", 0, 16384);
        u_if.alpha = -16'sd16384; u_if.beta = 16'sd0; u_if.in_valid = 1'b1;
        early = 0; changed = 0; n = 0;
        while (period_start !== 1'b1 && n < 2100) begin
            if (u_if.in_ready !== 1'b0) early++;
            if (pwm_a !== 1'b1 || pwm_b !== 1'b0 || pwm_c !== 1'b0 || sector !== 3'd1) changed++;
            tick();
            n++;
        end
        check("t5_ready_early", early, 0);
        check("t5_outputs_early", changed, 0);
        check("t5_valley", period_start, 1);
        check("t5_ready_after_valley", u_if.in_ready, 1);
        tick();
        u_if.in_valid = 1'b0;
        check("t5_busy_s2", u_if.in_ready, 0);
        tick();
        check("t5_s1_sector", sector, 2);
        check("t5_s1_cmp_a", dut.act_a_q, 500);
        check("t5_s1_cmp_b", dut.act_b_q, 933);
        check("t5_s1_cmp_c", dut.act_c_q, 67);
        changed = 0; n = 0;
        while (period_start !== 1'b1 && n < 2100) begin
            if (sector !== 3'd2) changed++;
            tick();
            n++;
        end
        check("t5_s2_not_early", changed, 0);
        check("t5_valley2", period_start, 1);
        tick();
        check("t5_s2_sector", sector, 3);
        check("t5_s2_cmp_a", dut.act_a_q, 125);
        check("t5_s2_cmp_b", dut.act_b_q, 875);
        check("t5_s2_cmp_c", dut.act_c_q, 875);

        // Reset in the middle of a period
        for (int i = 0; i < 100; i++) tick();
        check("t1_pre_pwm_b", pwm_b, 1);
        rst_n = 1'b0;
        #1;
        check("t1_pwm_a", pwm_a, 0);
        check("t1_pwm_b", pwm_b, 0);
        check("t1_pwm_c", pwm_c, 0);
        check("t1_ready", u_if.in_ready, 1);
        check("t1_cnt", dut.cnt_q, 0);
        check("t1_sector", sector, 1);
        tick(); tick();
        rst_n = 1'b1;
        wait_ps("t1");
        expect_period("t1", 0, 0, 0, 1, 2000, 1);

        // Angle sweep at |V| = 0.5, 30-degree steps offset by 15 degrees
        for (int i = 0; i < 12; i++) begin
            send($sformatf("t6_%0d", i), sw_al[i], sw_be[i]);
            wait_ps($sformatf("t6_%0d", i));
            tick(); tick();
            check($sformatf("t6_%0d_sector", i), sector, sw_sec[i]);
            check($sformatf("t6_%0d_cmp_a", i), dut.act_a_q, ref_cmp(sw_al[i], sw_be[i], 0));
            check($sformatf("t6_%0d_cmp_b", i), dut.act_b_q, ref_cmp(sw_al[i], sw_be[i], 1));
            check($sformatf("t6_%0d_cmp_c", i), dut.act_c_q, ref_cmp(sw_al[i], sw_be[i], 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
